// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave that serialises accesses onto a strobe/ack local register bus.
// Optional ack-wait timeout is compiled in with `define REG_TIMEOUT_EN.
module axi_lite_reg_bridge #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 11,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   reg_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg_wdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] reg_wstrb,
  output logic                            reg_wr,
  output logic                            reg_rd,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   reg_rdata,
  input  logic                            reg_ack,
  input  logic                            reg_err
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic            grant_wr_reg, grant_wr_next;
  logic            ready_en_reg;
  logic            aw_full_reg, w_full_reg, ar_full_reg;
  logic [AW-1:0]   aw_addr_reg, ar_addr_reg;
  logic [DW-1:0]   w_data_reg;
  logic [SW-1:0]   w_strb_reg;
  logic [1:0]      bresp_reg, rresp_reg;
  logic [DW-1:0]   rdata_reg;
  logic            wr_elig, rd_elig, ack_ok, timeout, b_hs, r_hs;

  assign wr_elig = aw_full_reg & w_full_reg;
  assign rd_elig = ar_full_reg;
  assign ack_ok  = reg_ack && (state_reg == ISSUE || state_reg == WAIT);
  assign b_hs    = S_AXI_BVALID & S_AXI_BREADY;
  assign r_hs    = S_AXI_RVALID & S_AXI_RREADY;

`ifdef REG_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset || state_reg != WAIT) wait_cnt_reg <= '0;
    else                            wait_cnt_reg <= wait_cnt_reg + 1'b1;
  end

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle that still has no ack.
  assign timeout = (state_reg == WAIT) && !reg_ack &&
                   (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      grant_wr_reg <= 1'b1;  // so the first contested grant goes to read
    end else begin
      state_reg    <= state_next;
      grant_wr_reg <= grant_wr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_wr_next = grant_wr_reg;
    case (state_reg)
      IDLE: begin
        if (wr_elig && (!rd_elig || !grant_wr_reg)) begin
          state_next    = ISSUE;
          grant_wr_next = 1'b1;
        end else if (rd_elig) begin
          state_next    = ISSUE;
          grant_wr_next = 1'b0;
        end
      end
      ISSUE:   state_next = ack_ok ? RESP : WAIT;
      WAIT:    if (ack_ok || timeout) state_next = RESP;
      RESP:    if (b_hs || r_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    reg_wr       = 1'b0;
    reg_rd       = 1'b0;
    S_AXI_BVALID = 1'b0;
    S_AXI_RVALID = 1'b0;
    case (state_reg)
      ISSUE: begin
        reg_wr = grant_wr_reg;
        reg_rd = !grant_wr_reg;
      end
      RESP: begin
        S_AXI_BVALID = grant_wr_reg;
        S_AXI_RVALID = !grant_wr_reg;
      end
      default: ;
    endcase
  end

  // Holding registers stay full until their response handshakes, which keeps
  // the local-bus fields stable for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_en_reg <= 1'b0;
      aw_full_reg  <= 1'b0;
      w_full_reg   <= 1'b0;
      ar_full_reg  <= 1'b0;
      aw_addr_reg  <= '0;
      ar_addr_reg  <= '0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      bresp_reg    <= 2'b00;
      rresp_reg    <= 2'b00;
      rdata_reg    <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_full_reg <= 1'b1;
        aw_addr_reg <= S_AXI_AWADDR;
      end else if (b_hs) begin
        aw_full_reg <= 1'b0;
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_full_reg <= 1'b1;
        w_data_reg <= S_AXI_WDATA;
        w_strb_reg <= S_AXI_WSTRB;
      end else if (b_hs) begin
        w_full_reg <= 1'b0;
      end
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        ar_full_reg <= 1'b1;
        ar_addr_reg <= S_AXI_ARADDR;
      end else if (r_hs) begin
        ar_full_reg <= 1'b0;
      end
      if (ack_ok || timeout) begin
        if (grant_wr_reg) begin
          bresp_reg <= (timeout || reg_err) ? 2'b10 : 2'b00;
        end else begin
          rresp_reg <= (timeout || reg_err) ? 2'b10 : 2'b00;
          rdata_reg <= timeout ? '1 : reg_rdata;
        end
      end
    end
  end

  assign S_AXI_AWREADY = ready_en_reg & !aw_full_reg;
  assign S_AXI_WREADY  = ready_en_reg & !w_full_reg;
  assign S_AXI_ARREADY = ready_en_reg & !ar_full_reg;
  assign S_AXI_BRESP   = bresp_reg;
  assign S_AXI_RRESP   = rresp_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign reg_addr      = grant_wr_reg ? aw_addr_reg : ar_addr_reg;
  assign reg_wdata     = w_data_reg;
  assign reg_wstrb     = w_strb_reg;
endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Self-checking bench for axi_lite_reg_bridge: directed corner cases plus random
// traffic checked against a word-addressed memory model and the alternating grant rule.
module tb_axi_lite_reg_bridge;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int SW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic          S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [DW-1:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [SW-1:0] S_AXI_WSTRB;
  logic [1:0]    S_AXI_BRESP, S_AXI_RRESP;
  logic          S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic          S_AXI_RVALID, S_AXI_RREADY;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata, reg_rdata;
  logic [SW-1:0] reg_wstrb;
  logic          reg_wr, reg_rd, reg_ack, reg_err;

  axi_lite_reg_bridge #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb), .reg_wr(reg_wr),
    .reg_rd(reg_rd), .reg_rdata(reg_rdata), .reg_ack(reg_ack), .reg_err(reg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    strb;
  } acc_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_strobes = 0;
  int          n_issued = 0;
  int          fixed_delay = -1;
  bit          hold_ack = 1'b0;
  bit          late_ack_req = 1'b0;
  bit          model_last_wr = 1'b1;
  acc_t        exp_q[$];
  acc_t        cur;
  logic [31:0] model_mem [256];
  logic [31:0] slave_mem [256];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Local bus rule used by both the slave and the model: addr bit 10 set => error.
  function automatic logic is_err(input logic [AW-1:0] a);
    return a[10];
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [7:0] idx;
    logic       e;
    idx = 8'($urandom_range(0, 15));
    e   = ($urandom_range(0, 7) == 0);
    return {e, idx, 2'b00};
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_q.push_back('{wr: 1'b1, addr: a, data: d, strb: s});
    n_issued++;
    if (!is_err(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
    model_last_wr = 1'b1;
  endtask

  task automatic model_read(input logic [AW-1:0] a, output logic [31:0] d);
    exp_q.push_back('{wr: 1'b0, addr: a, data: 32'h0, strb: 4'h0});
    n_issued++;
    d = model_mem[a[9:2]];
    model_last_wr = 1'b0;
  endtask

  // Local register slave: checks every strobe against the expected access order.
  initial begin : responder
    bit pend;
    bit prev_strobe;
    int cnt;
    acc_t e;
    pend = 1'b0; prev_strobe = 1'b0; cnt = 0;
    reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0;
    forever begin
      @(negedge clk);
      reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0;
      if (reset) begin
        pend = 1'b0;
        prev_strobe = 1'b0;
      end else begin
        if (late_ack_req) begin
          reg_ack = 1'b1; reg_rdata = 32'hDEAD_BEEF; late_ack_req = 1'b0;
        end
        if (reg_wr || reg_rd) begin
          n_strobes++;
          check_val("strobe_single_cycle", prev_strobe, 0);
          check_val("strobe_exclusive", reg_wr & reg_rd, 0);
          cur = '{wr: reg_wr, addr: reg_addr, data: reg_wdata, strb: reg_wstrb};
          check_val("strobe_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("strobe_dir", reg_wr, e.wr);
            check_val("reg_addr", reg_addr, e.addr);
            if (e.wr) begin
              check_val("reg_wdata", reg_wdata, e.data);
              check_val("reg_wstrb", reg_wstrb, e.strb);
            end
          end
          pend = !hold_ack;
          cnt  = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
        end else if (pend) begin
          check_val("reg_addr_stable", reg_addr, cur.addr);
        end
        prev_strobe = reg_wr | reg_rd;
        if (pend) begin
          if (cnt == 0) begin
            pend = 1'b0; reg_ack = 1'b1; reg_err = is_err(cur.addr);
            if (cur.wr) begin
              if (!reg_err)
                for (int b = 0; b < 4; b++)
                  if (cur.strb[b]) slave_mem[cur.addr[9:2]][8*b +: 8] = cur.data[8*b +: 8];
            end else begin
              reg_rdata = slave_mem[cur.addr[9:2]];
            end
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_ready_valid_strobe"}, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
              S_AXI_BVALID, S_AXI_RVALID, reg_wr, reg_rd}, 0);
    check_val({tag, "_resp"}, {S_AXI_BRESP, S_AXI_RRESP}, 0);
    check_val({tag, "_rdata"}, S_AXI_RDATA, 0);
    check_val({tag, "_reg_addr"}, reg_addr, 0);
  endtask

  task automatic apply_reset(input int cycles, input string tag);
    reset = 1'b1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    repeat (cycles) @(negedge clk);
    check_outputs_zero(tag);
    reset = 1'b0;
    model_last_wr = 1'b1;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic wait_ready(input bit need_aw, input bit need_w, input bit need_ar);
    int t = 0;
    while (((need_aw && !S_AXI_AWREADY) || (need_w && !S_AXI_WREADY) ||
            (need_ar && !S_AXI_ARREADY)) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_val("ready_within_bound", t < 50, 1);
  endtask

  task automatic drive_req(input bit aw, input bit w, input bit ar, input logic [AW-1:0] wa,
                           input logic [31:0] wd, input logic [3:0] ws, input logic [AW-1:0] ra);
    wait_ready(aw, w, ar);
    S_AXI_AWVALID = aw; S_AXI_AWADDR = wa;
    S_AXI_WVALID  = w;  S_AXI_WDATA  = wd; S_AXI_WSTRB = ws;
    S_AXI_ARVALID = ar; S_AXI_ARADDR = ra;
    @(negedge clk);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
  endtask

  task automatic wait_b(input logic [1:0] exp_br, input string tag);
    int t = 0;
    while (!S_AXI_BVALID && t < 100) begin @(negedge clk); t++; end
    check_val({tag, "_bvalid"}, S_AXI_BVALID, 1);
    check_val({tag, "_bresp"}, S_AXI_BRESP, exp_br);
    $display("%s: B resp=%0d", tag, S_AXI_BRESP);
    S_AXI_BREADY = 1'b1;
    @(negedge clk);
    S_AXI_BREADY = 1'b0;
    check_val({tag, "_bvalid_drop"}, S_AXI_BVALID, 0);
  endtask

  task automatic wait_r(input logic [1:0] exp_rr, input logic [31:0] exp_rd, input string tag);
    int t = 0;
    while (!S_AXI_RVALID && t < 100) begin @(negedge clk); t++; end
    check_val({tag, "_rvalid"}, S_AXI_RVALID, 1);
    check_val({tag, "_rresp"}, S_AXI_RRESP, exp_rr);
    check_val({tag, "_rdata"}, S_AXI_RDATA, exp_rd);
    $display("%s: R resp=%0d data=0x%08h", tag, S_AXI_RRESP, S_AXI_RDATA);
    S_AXI_RREADY = 1'b1;
    @(negedge clk);
    S_AXI_RREADY = 1'b0;
    check_val({tag, "_rvalid_drop"}, S_AXI_RVALID, 0);
  endtask

  // One write, one read, or both presented in the same cycle with random B/R backpressure.
  task automatic do_access(input bit w, input bit r, input logic [AW-1:0] wa,
                           input logic [31:0] wd, input logic [3:0] ws, input logic [AW-1:0] ra);
    logic [31:0] exp_rd;
    bit w_done, r_done;
    int t;
    exp_rd = '0;
    if (w && r && model_last_wr) begin
      model_read(ra, exp_rd);
      model_write(wa, wd, ws);
    end else begin
      if (w) model_write(wa, wd, ws);
      if (r) model_read(ra, exp_rd);
    end
    drive_req(w, w, r, wa, wd, ws, ra);
    w_done = !w; r_done = !r; t = 0;
    while (!(w_done && r_done) && t < 200) begin
      S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
      if (!w_done && S_AXI_BVALID && $urandom_range(0, 2) != 0) begin
        check_val("rand_bresp", S_AXI_BRESP, is_err(wa) ? 2'b10 : 2'b00);
        $display("wr addr=0x%03h data=0x%08h strb=0x%1h bresp=%0d", wa, wd, ws, S_AXI_BRESP);
        S_AXI_BREADY = 1'b1; w_done = 1'b1;
      end
      if (!r_done && S_AXI_RVALID && $urandom_range(0, 2) != 0) begin
        check_val("rand_rresp", S_AXI_RRESP, is_err(ra) ? 2'b10 : 2'b00);
        check_val("rand_rdata", S_AXI_RDATA, exp_rd);
        $display("rd addr=0x%03h rdata=0x%08h rresp=%0d", ra, S_AXI_RDATA, S_AXI_RRESP);
        S_AXI_RREADY = 1'b1; r_done = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    check_val("rand_resp_done", {w_done, r_done}, 2'b11);
  endtask

  initial begin : main
    logic [31:0] exp_rd;
    int t, s0;
    reset = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    for (int i = 0; i < 256; i++) begin model_mem[i] = '0; slave_mem[i] = '0; end
    @(negedge clk);
    apply_reset(3, "por");

    // Write with same-cycle ack: strobe one cycle after capture, BVALID one cycle later.
    fixed_delay = 0;
    model_write(11'h004, 32'hA5A5_0001, 4'hF);
    drive_req(1, 1, 0, 11'h004, 32'hA5A5_0001, 4'hF, '0);
    check_val("lat_capture_no_strobe", reg_wr, 0);
    check_val("lat_capture_no_bvalid", S_AXI_BVALID, 0);
    @(negedge clk);
    check_val("lat_strobe_cycle", reg_wr, 1);
    @(negedge clk);
    check_val("lat_strobe_ended", reg_wr, 0);
    check_val("lat_bvalid", S_AXI_BVALID, 1);
    check_val("lat_bresp", S_AXI_BRESP, 2'b00);
    $display("wr addr=0x004 data=0xa5a50001 strb=0xf bresp=%0d", S_AXI_BRESP);
    S_AXI_BREADY = 1'b1;
    @(negedge clk);
    S_AXI_BREADY = 1'b0;
    check_val("lat_bvalid_drop", S_AXI_BVALID, 0);
    fixed_delay = -1;

    // Read with 3-cycle ack delay and 4 cycles of RREADY low.
    do_access(1, 0, 11'h010, 32'h1234_5678, 4'hF, '0);
    fixed_delay = 3;
    model_read(11'h010, exp_rd);
    drive_req(0, 0, 1, '0, '0, '0, 11'h010);
    t = 0;
    while (!S_AXI_RVALID && t < 50) begin @(negedge clk); t++; end
    for (int k = 0; k < 4; k++) begin
      check_val("hold_rvalid", S_AXI_RVALID, 1);
      check_val("hold_rdata", S_AXI_RDATA, 32'h1234_5678);
      check_val("hold_rresp", S_AXI_RRESP, 2'b00);
      @(negedge clk);
    end
    wait_r(2'b00, 32'h1234_5678, "hold_release");
    fixed_delay = -1;

    // Simultaneous AW+W+AR straight after reset: read must be granted first.
    apply_reset(2, "rst2");
    do_access(1, 1, 11'h008, 32'hCAFE_0002, 4'h3, 11'h004);
    do_access(1, 1, 11'h00C, 32'h0000_00FF, 4'h1, 11'h008);

    // Error response on read.
    do_access(0, 1, '0, '0, '0, 11'h404);

    // AW without W never issues; completes once W arrives.
    model_write(11'h014, 32'h0BAD_F00D, 4'hF);
    s0 = n_strobes;
    drive_req(1, 0, 0, 11'h014, '0, '0, '0);
    repeat (8) @(negedge clk);
    check_val("aw_only_no_strobe", n_strobes - s0, 0);
    check_val("aw_only_no_bvalid", S_AXI_BVALID, 0);
    check_val("aw_only_awready_low", S_AXI_AWREADY, 0);
    drive_req(0, 1, 0, '0, 32'h0BAD_F00D, 4'hF, '0);
    wait_b(2'b00, "aw_then_w");

    // Reset during WAIT followed by a late ack: nothing must come out.
    hold_ack = 1'b1;
    model_read(11'h020, exp_rd);
    drive_req(0, 0, 1, '0, '0, '0, 11'h020);
    t = 0;
    while (!reg_rd && t < 20) begin @(negedge clk); t++; end
    check_val("midrst_strobe_seen", reg_rd, 1);
    repeat (2) @(negedge clk);
    check_val("midrst_in_wait", {S_AXI_RVALID, reg_rd}, 0);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    reset = 1'b0; late_ack_req = 1'b1; hold_ack = 1'b0;
    model_last_wr = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val("midrst_quiet", {S_AXI_BVALID, S_AXI_RVALID, reg_wr, reg_rd}, 0);
    end
    check_val("midrst_rdata_zero", S_AXI_RDATA, 0);

`ifdef REG_TIMEOUT_EN
    hold_ack = 1'b1;
    model_read(11'h030, exp_rd);
    drive_req(0, 0, 1, '0, '0, '0, 11'h030);
    t = 0;
    while (!reg_rd && t < 20) begin @(negedge clk); t++; end
    check_val("to_strobe_seen", reg_rd, 1);
    t = 0;
    while (!S_AXI_RVALID && t < 50) begin @(negedge clk); t++; end
    check_val("to_issue_to_resp_cycles", t, TO + 1);
    wait_r(2'b10, 32'hFFFF_FFFF, "timeout_read");
    hold_ack = 1'b0;
`endif

    for (int i = 0; i < 120; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      do_access(kind != 1, kind != 0, rand_addr(), $urandom, 4'($urandom_range(0, 15)), rand_addr());
    end

    repeat (4) @(negedge clk);
    check_val("strobe_count", n_strobes, n_issued);
    check_val("expectations_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
